// File: rtl/lam_dep_xung_nkenh.sv
// N-channel button conditioner: two-flop synchroniser, stable-time debounce,
// press/release pulses and optional auto-repeat per channel.
module lam_dep_xung_nkenh #(
  parameter int N          = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int STABLE     = 250000,
  parameter int REP_EN     = 0,
  parameter int REP_DLY    = 25000000,
  parameter int REP_PER    = 5000000
) (
  input  logic         ckht,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] xung_nhan,
  output logic [N-1:0] xung_nha,
  output logic [N-1:0] xung_lap
);

  localparam int              CW       = $clog2(STABLE) + 1;
  localparam logic [CW-1:0]   CNT_TOP  = CW'(STABLE - 1);
  localparam logic            IDLE_LVL = (ACTIVE_LOW != 0);

  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    logic          sync1, sync2, s;
    logic [CW-1:0] cnt;
    logic          q_r, nhan_r, nha_r;
    logic          fire, press_ev, rel_ev;

    always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= IDLE_LVL;
        sync2 <= IDLE_LVL;
      end else begin
        sync1 <= d[i];
        sync2 <= sync1;
      end
    end

    assign s        = sync2 ^ IDLE_LVL;
    assign fire     = (s != q_r) && (cnt == CNT_TOP);
    assign press_ev = fire & ~q_r;
    assign rel_ev   = fire &  q_r;

    always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        q_r    <= 1'b0;
        nhan_r <= 1'b0;
        nha_r  <= 1'b0;
      end else begin
        nhan_r <= press_ev;
        nha_r  <= rel_ev;
        if (s == q_r || fire) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (fire) begin
          q_r <= ~q_r;
        end
      end
    end

    assign q[i]         = q_r;
    assign xung_nhan[i] = nhan_r;
    assign xung_nha[i]  = nha_r;

    if (REP_EN != 0) begin : g_rep
      localparam int            RMAX    = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
      localparam int            RW      = $clog2(RMAX) + 1;
      localparam logic [RW-1:0] DLY_TOP = RW'(REP_DLY - 1);
      localparam logic [RW-1:0] PER_TOP = RW'(REP_PER - 1);

      typedef enum logic [1:0] {IDLE, DLY, REP} rep_state_t;

      rep_state_t    st, st_n;
      logic [RW-1:0] rc, rc_n;
      logic          lap_r, lap_n;

      always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
          st    <= IDLE;
          rc    <= '0;
          lap_r <= 1'b0;
        end else begin
          st    <= st_n;
          rc    <= rc_n;
          lap_r <= lap_n;
        end
      end

      // Press/release come from the debounce decision itself, not the
      // registered pulses, so the FSM leaves DLY/REP on the release edge.
      always_comb begin
        st_n  = st;
        rc_n  = rc;
        lap_n = 1'b0;
        case (st)
          IDLE: begin
            rc_n = '0;
            if (press_ev) st_n = DLY;
          end
          DLY: begin
            if (rel_ev) begin
              st_n = IDLE;
              rc_n = '0;
            end else if (rc == DLY_TOP) begin
              lap_n = 1'b1;
              rc_n  = '0;
              st_n  = REP;
            end else begin
              rc_n = rc + RW'(1);
            end
          end
          REP: begin
            if (rel_ev) begin
              st_n = IDLE;
              rc_n = '0;
            end else if (rc == PER_TOP) begin
              lap_n = 1'b1;
              rc_n  = '0;
            end else begin
              rc_n = rc + RW'(1);
            end
          end
          default: begin
            st_n = IDLE;
            rc_n = '0;
          end
        endcase
      end

      assign xung_lap[i] = lap_r;
    end else begin : g_norep
      assign xung_lap[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_lam_dep_xung_nkenh.sv
// Directed bench for lam_dep_xung_nkenh with N=2, STABLE=4, REP_DLY=10, REP_PER=3.
module tb_lam_dep_xung_nkenh;

  logic       ckht = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] d = 2'b11;
  logic [1:0] q, xung_nhan, xung_nha, xung_lap;

  int errors = 0;
  int checks = 0;

  lam_dep_xung_nkenh #(
    .N(2), .ACTIVE_LOW(1), .STABLE(4), .REP_EN(1), .REP_DLY(10), .REP_PER(3)
  ) dut (
    .ckht(ckht), .rst_n(rst_n), .d(d), .q(q),
    .xung_nhan(xung_nhan), .xung_nha(xung_nha), .xung_lap(xung_lap)
  );

  always #5 ckht = ~ckht;

  task automatic tick();
    @(posedge ckht);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    logic [7:0] acc;
    d = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q, xung_nhan, xung_nha, xung_lap} !== 8'h00) begin
      errors++;
      $display("FAIL reset_entry: got %b want 00000000", {q, xung_nhan, xung_nha, xung_lap});
    end
    ticks(3);
    checks++;
    if ({q, xung_nhan, xung_nha, xung_lap} !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: got %b want 00000000", {q, xung_nhan, xung_nha, xung_lap});
    end
    d = 2'b11;
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 50; k++) begin
      tick();
      acc |= {q, xung_nhan, xung_nha, xung_lap};
    end
    checks++;
    if (acc !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_quiet: got %b want 00000000", acc);
    end
  endtask

  task automatic test_clean_press();
    d[0] = 1'b0;
    ticks(5);
    checks++;
    if ({q, xung_nhan} !== 4'b0000) begin
      errors++;
      $display("FAIL press_early: got %b want 0000", {q, xung_nhan});
    end
    tick();
    checks++;
    if ({q, xung_nhan, xung_nha} !== 6'b01_01_00) begin
      errors++;
      $display("FAIL press_edge: got %b want 010100", {q, xung_nhan, xung_nha});
    end
    tick();
    checks++;
    if ({q, xung_nhan} !== 4'b01_00) begin
      errors++;
      $display("FAIL press_pulse_end: got %b want 0100", {q, xung_nhan});
    end
    d[0] = 1'b1;
    ticks(5);
    checks++;
    if ({q, xung_nha} !== 4'b01_00) begin
      errors++;
      $display("FAIL release_early: got %b want 0100", {q, xung_nha});
    end
    tick();
    checks++;
    if ({q, xung_nha, xung_lap} !== 6'b00_01_00) begin
      errors++;
      $display("FAIL release_edge: got %b want 000100", {q, xung_nha, xung_lap});
    end
    ticks(5);
  endtask

  task automatic test_bounce();
    logic [1:0] acc;
    int npress;
    acc = '0;
    for (int j = 0; j < 10; j++) begin
      d[0] = (j % 2 == 1);
      for (int k = 0; k < 2; k++) begin
        tick();
        acc |= {q[0], xung_nhan[0]};
      end
    end
    checks++;
    if (acc !== 2'b00) begin
      errors++;
      $display("FAIL bounce_ignored: got %b want 00", acc);
    end
    d[0] = 1'b0;
    npress = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (xung_nhan[0]) npress++;
    end
    checks++;
    if ({xung_nhan[0], npress} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL bounce_settle: got pulse=%b count=%0d want pulse=1 count=1", xung_nhan[0], npress);
    end
  endtask

  task automatic test_hold_release();
    logic exp_lap, exp_nha;
    logic acc;
    for (int k = 1; k <= 36; k++) begin
      if (k == 31) d[0] = 1'b1;
      tick();
      exp_lap = (k >= 10) && (k < 36) && ((k - 10) % 3 == 0);
      exp_nha = (k == 36);
      checks++;
      if ({xung_lap, xung_nha[0], xung_nhan[0]} !== {1'b0, exp_lap, exp_nha, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got lap=%b nha=%b nhan=%b want lap=0%b nha=%b nhan=0",
                 k, xung_lap, xung_nha[0], xung_nhan[0], exp_lap, exp_nha);
      end
    end
    checks++;
    if (q !== 2'b00) begin
      errors++;
      $display("FAIL release_q: got %b want 00", q);
    end
    acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc |= |xung_lap;
    end
    checks++;
    if (acc !== 1'b0) begin
      errors++;
      $display("FAIL no_lap_after_release: got %b want 0", acc);
    end
  endtask

  task automatic test_simultaneous();
    d = 2'b00;
    ticks(5);
    checks++;
    if (xung_nhan !== 2'b00) begin
      errors++;
      $display("FAIL both_early: got %b want 00", xung_nhan);
    end
    tick();
    checks++;
    if ({q, xung_nhan} !== 4'b11_11) begin
      errors++;
      $display("FAIL both_press: got %b want 1111", {q, xung_nhan});
    end
    d = 2'b10;
    ticks(5);
    checks++;
    if (xung_nha !== 2'b00) begin
      errors++;
      $display("FAIL ch1_release_early: got %b want 00", xung_nha);
    end
    tick();
    checks++;
    if ({q, xung_nhan, xung_nha} !== 6'b01_00_10) begin
      errors++;
      $display("FAIL ch1_release: got %b want 010010", {q, xung_nhan, xung_nha});
    end
    ticks(3);
    tick();
    checks++;
    if (xung_lap !== 2'b01) begin
      errors++;
      $display("FAIL ch0_first_lap: got %b want 01", xung_lap);
    end
  endtask

  task automatic test_reset_mid();
    ticks(3);
    checks++;
    if (xung_lap !== 2'b01) begin
      errors++;
      $display("FAIL ch0_rep_lap: got %b want 01", xung_lap);
    end
    tick();
    d = 2'b11;
    ticks(5);
    checks++;
    if ({q, xung_lap} !== 4'b01_01) begin
      errors++;
      $display("FAIL pre_reset_state: got %b want 0101", {q, xung_lap});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({q, xung_nhan, xung_nha, xung_lap} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_clear: got %b want 00000000", {q, xung_nhan, xung_nha, xung_lap});
    end
    d = 2'b00;
    ticks(3);
    checks++;
    if ({q, xung_nhan, xung_nha, xung_lap} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_held: got %b want 00000000", {q, xung_nhan, xung_nha, xung_lap});
    end
    rst_n = 1'b1;
    ticks(5);
    checks++;
    if ({q, xung_nhan} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_early: got %b want 0000", {q, xung_nhan});
    end
    tick();
    checks++;
    if ({q, xung_nhan, xung_nha} !== 6'b11_11_00) begin
      errors++;
      $display("FAIL post_reset_press: got %b want 111100", {q, xung_nhan, xung_nha});
    end
    tick();
    checks++;
    if ({xung_nhan, xung_lap} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_pulse_end: got %b want 0000", {xung_nhan, xung_lap});
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_release();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
